// File: rtl/muxn_pkg.sv
// Shared types and constants for the muxn_sync registered channel multiplexer.
package muxn_pkg;

    typedef enum logic {
        RUN = 1'b0,
        GAP = 1'b1
    } muxn_state_e;

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;
    localparam int               GAP_W   = 4;

    // Select width: clog2(n), but never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muxn_sync_if.sv
// Channel, select handshake and status bundle of muxn_sync.
interface muxn_sync_if #(
    parameter int N = 4,
    parameter int W = 8
) ();
    localparam int SW = muxn_pkg::sel_width(N);

    logic [N*W-1:0]             in_data;
    logic [SW-1:0]              sel_req;
    logic                       sel_valid;
    logic                       sel_ready;
    logic [W-1:0]               out_data;
    logic                       out_valid;
    logic [SW-1:0]              cur_sel;
    logic [muxn_pkg::CNT_W-1:0] switch_cnt;
    logic                       sel_err;
    logic                       trig_out;
    logic [3:0]                 dbg_data;

    modport master (
        output in_data, sel_req, sel_valid,
        input  sel_ready, out_data, out_valid, cur_sel, switch_cnt, sel_err,
               trig_out, dbg_data
    );

    modport slave (
        input  in_data, sel_req, sel_valid,
        output sel_ready, out_data, out_valid, cur_sel, switch_cnt, sel_err,
               trig_out, dbg_data
    );
endinterface

// File: rtl/muxn_gap_ctrl.sv
// Select handshake, break-before-make gap timer and switch statistics.
// MUXN_SYNC_TRIG_EN enables the registered trig_out pulse and dbg_data nibble.
//
// state | meaning
// RUN   | output follows cur_sel, select requests accepted
// GAP   | channel switch in progress, output forced invalid
module muxn_gap_ctrl
    import muxn_pkg::*;
#(
    parameter int N           = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int RESET_SEL   = 0,
    parameter int SW          = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SW-1:0]    sel_req,
    input  logic             sel_valid,
    output logic             sel_ready,
    output logic [SW-1:0]    cur_sel,
    output logic [CNT_W-1:0] switch_cnt,
    output logic             sel_err,
    output logic             load_en,
    output logic             trig_out,
    output logic [3:0]       dbg_data
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(DEAD_CYCLES - 1);
    localparam logic [SW:0]      N_LIM    = (SW+1)'(N);
    localparam logic [SW-1:0]    SEL_RST  = SW'(RESET_SEL);

    muxn_state_e      state_q, state_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             accept;
    logic             req_bad;

    assign accept  = sel_valid & sel_ready;
    assign req_bad = {1'b0, sel_req} >= N_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            gap_q   <= '0;
            sel_q   <= SEL_RST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (accept) begin
                    // Bad and same-channel requests are consumed without a gap.
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else if (sel_req != sel_q) begin
                        sel_d   = sel_req;
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    state_d = RUN;
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        sel_ready = (state_q == RUN);
        load_en   = (state_d == RUN);
    end

    assign cur_sel    = sel_q;
    assign switch_cnt = cnt_q;
    assign sel_err    = err_q;

`ifdef MUXN_SYNC_TRIG_EN
    logic       trig_q;
    logic [3:0] dbg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
            dbg_q  <= '0;
        end else begin
            trig_q <= (state_q == GAP) && (state_d == RUN);
            dbg_q  <= {state_d == GAP, 3'(sel_d)};
        end
    end

    assign trig_out = trig_q;
    assign dbg_data = dbg_q;
`else
    assign trig_out = 1'b0;
    assign dbg_data = 4'h0;
`endif

endmodule

// File: rtl/muxn_sync.sv
// N-input, W-bit registered multiplexer with handshaked break-before-make switching.
// Optional debug trigger/nibble outputs are enabled by MUXN_SYNC_TRIG_EN.
module muxn_sync
    import muxn_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int DEAD_CYCLES = 2,
    parameter int RESET_SEL   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    muxn_sync_if.slave  bus
);

    localparam int SW = sel_width(N);

    logic [SW-1:0]    cur_sel;
    logic [CNT_W-1:0] switch_cnt;
    logic             sel_ready;
    logic             sel_err;
    logic             load_en;
    logic             trig_out;
    logic [3:0]       dbg_data;
    logic [W-1:0]     sel_data;
    logic [W-1:0]     out_data_q;
    logic             out_valid_q;

    muxn_gap_ctrl #(
        .N           (N),
        .DEAD_CYCLES (DEAD_CYCLES),
        .RESET_SEL   (RESET_SEL),
        .SW          (SW)
    ) u_gap_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_req    (bus.sel_req),
        .sel_valid  (bus.sel_valid),
        .sel_ready  (sel_ready),
        .cur_sel    (cur_sel),
        .switch_cnt (switch_cnt),
        .sel_err    (sel_err),
        .load_en    (load_en),
        .trig_out   (trig_out),
        .dbg_data   (dbg_data)
    );

    // Compare-based pick so select codes beyond N never index past in_data.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (cur_sel == SW'(i)) begin
                sel_data = bus.in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= load_en;
            out_data_q  <= load_en ? sel_data : '0;
        end
    end

    assign bus.sel_ready  = sel_ready;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.cur_sel    = cur_sel;
    assign bus.switch_cnt = switch_cnt;
    assign bus.sel_err    = sel_err;
    assign bus.trig_out   = trig_out;
    assign bus.dbg_data   = dbg_data;

endmodule

// File: tb/tb_muxn_sync.sv
// Directed bench for muxn_sync: a 4-channel and a 3-channel instance on one clock.
module tb_muxn_sync;

`ifdef MUXN_SYNC_TRIG_EN
    localparam bit TRIG = 1'b1;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    muxn_sync_if #(.N(4), .W(8)) bus4 ();
    muxn_sync_if #(.N(3), .W(8)) bus3 ();

    muxn_sync #(.N(4), .W(8), .DEAD_CYCLES(2), .RESET_SEL(0)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    muxn_sync #(.N(3), .W(8), .DEAD_CYCLES(2), .RESET_SEL(0)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_cnt;
    logic [1:0] tgt;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus4.in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        bus4.sel_req   = 2'd0;
        bus4.sel_valid = 1'b0;
        bus3.in_data   = {8'h63, 8'h62, 8'h61};
        bus3.sel_req   = 2'd0;
        bus3.sel_valid = 1'b0;

        // Reset state
        tick();
        tick();
        check_val("rst_valid",  32'(bus4.out_valid),  32'd0);
        check_val("rst_data",   32'(bus4.out_data),   32'd0);
        check_val("rst_sel",    32'(bus4.cur_sel),    32'd0);
        check_val("rst_cnt",    32'(bus4.switch_cnt), 32'd0);
        check_val("rst_err",    32'(bus4.sel_err),    32'd0);
        check_val("rst_ready",  32'(bus4.sel_ready),  32'd1);
        check_val("rst_trig",   32'(bus4.trig_out),   32'd0);
        check_val("rst_dbg",    32'(bus4.dbg_data),   32'd0);

        // First edge after release gives channel 0
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("first_valid", 32'(bus4.out_valid), 32'd1);
        check_val("first_data",  32'(bus4.out_data),  32'h11);
        check_val("first_sel",   32'(bus4.cur_sel),   32'd0);
        check_val("first_ready", 32'(bus4.sel_ready), 32'd1);
        check_val("n3_first",    32'(bus3.out_data),  32'h61);

        // One-cycle latency from in_data to out_data
        bus4.in_data[7:0] = 8'h55;
        tick();
        check_val("lat_data", 32'(bus4.out_data), 32'h55);
        bus4.in_data[7:0] = 8'h11;
        tick();
        check_val("lat_back", 32'(bus4.out_data), 32'h11);

        // Switch to channel 2: two invalid cycles, requests ignored during the gap
        bus4.sel_req   = 2'd2;
        bus4.sel_valid = 1'b1;
        tick();
        check_val("gap1_valid", 32'(bus4.out_valid), 32'd0);
        check_val("gap1_data",  32'(bus4.out_data),  32'd0);
        check_val("gap1_sel",   32'(bus4.cur_sel),   32'd2);
        check_val("gap1_ready", 32'(bus4.sel_ready), 32'd0);
        check_val("gap1_dbg",   32'(bus4.dbg_data),  TRIG ? 32'hA : 32'h0);
        check_val("gap1_trig",  32'(bus4.trig_out),  32'd0);
        bus4.sel_req = 2'd1;
        bus4.in_data[23:16] = 8'h99;
        tick();
        check_val("gap2_valid", 32'(bus4.out_valid), 32'd0);
        check_val("gap2_data",  32'(bus4.out_data),  32'd0);
        check_val("gap2_ready", 32'(bus4.sel_ready), 32'd0);
        bus4.in_data[23:16] = 8'h33;
        tick();
        check_val("run_valid", 32'(bus4.out_valid),  32'd1);
        check_val("run_data",  32'(bus4.out_data),   32'h33);
        check_val("run_cnt",   32'(bus4.switch_cnt), 32'd1);
        check_val("run_trig",  32'(bus4.trig_out),   32'(TRIG));
        check_val("run_sel",   32'(bus4.cur_sel),    32'd2);
        check_val("run_dbg",   32'(bus4.dbg_data),   TRIG ? 32'h2 : 32'h0);
        bus4.sel_valid = 1'b0;
        tick();
        check_val("trig_once", 32'(bus4.trig_out), 32'd0);
        check_val("hold_sel",  32'(bus4.cur_sel),  32'd2);
        check_val("hold_data", 32'(bus4.out_data), 32'h33);

        // Same-channel request: no gap, no count
        bus4.sel_req   = 2'd2;
        bus4.sel_valid = 1'b1;
        tick();
        check_val("same_valid", 32'(bus4.out_valid),  32'd1);
        check_val("same_data",  32'(bus4.out_data),   32'h33);
        check_val("same_ready", 32'(bus4.sel_ready),  32'd1);
        tick();
        bus4.sel_valid = 1'b0;
        check_val("same_valid2", 32'(bus4.out_valid),  32'd1);
        check_val("same_cnt",    32'(bus4.switch_cnt), 32'd1);

        // Out-of-range select on the 3-channel instance
        bus3.sel_req   = 2'd3;
        bus3.sel_valid = 1'b1;
        tick();
        bus3.sel_valid = 1'b0;
        check_val("err_set",   32'(bus3.sel_err),   32'd1);
        check_val("err_sel",   32'(bus3.cur_sel),   32'd0);
        check_val("err_valid", 32'(bus3.out_valid), 32'd1);
        check_val("err_data",  32'(bus3.out_data),  32'h61);
        check_val("err_ready", 32'(bus3.sel_ready), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check_val("err_sticky", 32'(bus3.sel_err),    32'd1);
        check_val("err_nocnt",  32'(bus3.switch_cnt), 32'd0);

        // 260 alternating switches: counter saturates at 255
        exp_cnt = 1;
        for (int i = 0; i < 260; i++) begin
            tgt = (i % 2 == 0) ? 2'd0 : 2'd1;
            bus4.sel_req   = tgt;
            bus4.sel_valid = 1'b1;
            tick();
            bus4.sel_valid = 1'b0;
            check_val("sat_gap", 32'(bus4.out_valid), 32'd0);
            tick();
            tick();
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            check_val("sat_cnt", 32'(bus4.switch_cnt), 32'(exp_cnt));
        end
        check_val("sat_255",  32'(bus4.switch_cnt), 32'd255);
        check_val("sat_sel",  32'(bus4.cur_sel),    32'd1);
        check_val("sat_data", 32'(bus4.out_data),   32'h22);

        // Reset in the first gap cycle of a switch to channel 3
        bus4.in_data[7:0] = 8'h5A;
        bus4.sel_req      = 2'd3;
        bus4.sel_valid    = 1'b1;
        tick();
        bus4.sel_valid = 1'b0;
        check_val("abort_gap", 32'(bus4.out_valid), 32'd0);
        check_val("abort_tgt", 32'(bus4.cur_sel),   32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_valid", 32'(bus4.out_valid),  32'd0);
        check_val("abort_sel",   32'(bus4.cur_sel),    32'd0);
        check_val("abort_cnt",   32'(bus4.switch_cnt), 32'd0);
        check_val("abort_err3",  32'(bus3.sel_err),    32'd0);
        check_val("abort_ready", 32'(bus4.sel_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("rel_valid", 32'(bus4.out_valid), 32'd1);
        check_val("rel_data",  32'(bus4.out_data),  32'h5A);
        check_val("rel_sel",   32'(bus4.cur_sel),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muxn_sync.md
Name: muxn_sync

Overview:
- Parametrised N-input, W-bit registered multiplexer. Next generation of the team's gate-level 2:1 mux.
- Select changes go through a valid/ready handshake. Each real switch is break-before-make: output is forced invalid for DEAD_CYCLES clocks before the new channel appears.
- Keeps a saturating switch counter and a sticky error flag for bad selects.
- Feeds the debugware trigger/data inputs.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel (>=1).
- DEAD_CYCLES, 2, output-invalid gap on a channel switch (1..15).
- RESET_SEL, 0, channel selected out of reset (<N).
- SW (localparam), max(1, clog2(N)), select width.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- sel_req  input  SW  requested channel.
- sel_valid  input  1  select request valid.
- sel_ready  output  1  block can accept a select.
- out_data  output  W  registered selected data; 0 when out_valid=0.
- out_valid  output  1  out_data is from cur_sel.
- cur_sel  output  SW  currently committed channel.
- switch_cnt  output  8  count of completed switches, saturates at 255.
- sel_err  output  1  sticky; set by a select >= N.
- trig_out  output  1  debug trigger pulse (see Optional Feature).
- dbg_data  output  4  debug nibble (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async):
  - state=RUN, cur_sel=RESET_SEL, out_valid=0, out_data=0.
  - switch_cnt=0, sel_err=0, gap_cnt=0, trig_out=0, dbg_data=0.
- RUN:
  - sel_ready=1.
  - Each edge: out_data<=in_data[cur_sel], out_valid<=1.
  - Latency is one clock from in_data to out_data. First valid output is the first edge after reset release.
- Handshake: accept on sel_valid & sel_ready at an edge. sel_req is sampled only at acceptance.
  - sel_req == cur_sel: accepted, no gap, no count change, output uninterrupted.
  - sel_req >= N: accepted, sel_err<=1, cur_sel unchanged, no gap.
  - Otherwise: at that edge cur_sel<=sel_req, state<=GAP, gap_cnt<=DEAD_CYCLES-1, out_valid<=0, out_data<=0.
- GAP:
  - sel_ready=0; sel_valid is ignored (requester must hold it).
  - out_valid=0, out_data=0.
  - If gap_cnt!=0: gap_cnt decrements each edge.
  - If gap_cnt==0: at the next edge state<=RUN, out_valid<=1, out_data<=in_data[cur_sel], switch_cnt<=sat(switch_cnt+1).
  - out_valid is therefore low for exactly DEAD_CYCLES consecutive clocks per switch.
- switch_cnt holds at 255; it never wraps.
- sel_err clears only on reset.
- Reset asserted mid-GAP aborts the switch. cur_sel returns to RESET_SEL.
- in_data changes during GAP are not visible. Only the value at the RUN-entry edge appears.
- No combinational path from sel_valid to any output except sel_ready, which is a function of state only.

Optional Feature:
- Macro: MUXN_SYNC_TRIG_EN.
- Defined:
  - trig_out is a registered 1-clock pulse on every GAP->RUN edge, i.e. with the first valid cycle of the new channel.
  - dbg_data = {state==GAP, cur_sel[2:0]} (zero-extended if SW<3), registered.
- Undefined: trig_out and dbg_data are tied to 0. Ports remain so integration is unchanged.

Decomposition:
- Package muxn_pkg:
  - state encodings RUN=1'b0, GAP=1'b1.
  - CNT_W=8, CNT_MAX=8'hFF.
  - select-width function.
- Sub-module muxn_gap_ctrl: FSM, gap counter, handshake and switch counter.
- Top muxn_sync holds the data-path register and channel indexing.

Test Plan:
- Reset then release, N=4, W=8, in_data={8'h44,8'h33,8'h22,8'h11} -> out_data=8'h11, out_valid=1 on first edge after release; cur_sel=0, sel_ready=1.
- sel_req=2 accepted -> out_valid=0 and out_data=0 for exactly 2 clocks, then out_data=8'h33, switch_cnt=1, trig_out pulses once (macro defined).
- sel_req=2 while cur_sel=2 -> no gap, out_valid stays 1, switch_cnt unchanged.
- N=3, sel_req=3 -> sel_err=1 (sticky), cur_sel unchanged, no gap; sel_err still 1 after 10 further clocks.
- 260 alternating switches 0<->1 -> switch_cnt=255 and stays there.
- rst_n pulsed low in the 1st GAP cycle of a switch to 3 -> immediately out_valid=0, cur_sel=0; after release out_data=in_data[0].
